// File: rtl/wb_stage_pipe.sv
// Write-back stage: aligns and sign/zero-extends loads, picks the result source and registers the
// register-file write port. Optional retire counter is built when WB_RETIRE_CNT_EN is defined.
module wb_stage_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             m_valid_i,
  input  logic             flush_i,
  input  logic             reg_write_i,
  input  logic [RF_AW-1:0] rd_i,
  input  logic [1:0]       result_src_i,
  input  logic [2:0]       load_funct3_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  read_data_i,
  input  logic [XLEN-1:0]  pc_plus4_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             wb_valid_o,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             wb_misalign_o,
  output logic [CNT_W-1:0] retire_count_o
);

  typedef enum logic [1:0] {LdByte, LdHalf, LdWord} ld_kind_e;

  ld_kind_e         ld_kind;
  logic             ld_signed;
  logic [1:0]       offset;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  result;
  logic             misalign;
  logic             capture;

  logic             wb_valid_q;
  logic             rf_we_q,    rf_we_d;
  logic [RF_AW-1:0] rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             misalign_q;

  assign offset  = alu_result_i[1:0];
  assign capture = m_valid_i & ~flush_i;

  always_comb begin
    ld_kind   = LdWord;
    ld_signed = 1'b0;
    unique case (load_funct3_i)
      3'b000:  begin ld_kind = LdByte; ld_signed = 1'b1; end
      3'b001:  begin ld_kind = LdHalf; ld_signed = 1'b1; end
      3'b100:  ld_kind = LdByte;
      3'b101:  ld_kind = LdHalf;
      default: ld_kind = LdWord;  // 010 plus the unlisted codes
    endcase
  end

  always_comb begin
    unique case (offset)
      2'd0:    byte_sel = read_data_i[7:0];
      2'd1:    byte_sel = read_data_i[15:8];
      2'd2:    byte_sel = read_data_i[23:16];
      default: byte_sel = read_data_i[31:24];
    endcase
    half_sel = offset[1] ? read_data_i[31:16] : read_data_i[15:0];
  end

  always_comb begin
    load_data = read_data_i;
    misalign  = 1'b0;
    unique case (ld_kind)
      LdByte:  load_data = {{(XLEN-8){ld_signed & byte_sel[7]}}, byte_sel};
      LdHalf:  begin
        load_data = {{(XLEN-16){ld_signed & half_sel[15]}}, half_sel};
        misalign  = offset[0];
      end
      default: begin
        load_data = read_data_i;
        misalign  = |offset;
      end
    endcase
    // Alignment only matters when the load path is actually selected.
    if (result_src_i != 2'd1) misalign = 1'b0;
  end

  always_comb begin
    unique case (result_src_i)
      2'd0:    result = alu_result_i;
      2'd1:    result = load_data;
      2'd2:    result = pc_plus4_i;
      default: result = imm_i;
    endcase
    rf_wdata_d = misalign ? '0 : result;
    rf_we_d    = reg_write_i & (|rd_i) & ~misalign;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      wb_valid_q <= capture;
      rf_we_q    <= capture & rf_we_d;
      if (capture) begin
        rf_waddr_q <= rd_i;
        rf_wdata_q <= rf_wdata_d;
        misalign_q <= misalign;
      end
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign rf_we_o       = rf_we_q;
  assign rf_waddr_o    = rf_waddr_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign wb_misalign_o = misalign_q;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
    end else if (capture) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign retire_count_o = retire_cnt_q;
`else
  assign retire_count_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe (CNT_W=4): directed vectors with literal expectations plus a
// behavioural model compared on every falling clock edge.
module tb_wb_stage_pipe;

`ifdef WB_RETIRE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid, flush, reg_write;
  logic [4:0]  rd;
  logic [1:0]  result_src;
  logic [2:0]  load_funct3;
  logic [31:0] alu_result, read_data, pc_plus4, imm;
  logic        wb_valid, rf_we, wb_misalign;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  retire_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(32), .RF_AW(5), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .m_valid_i      (m_valid),
    .flush_i        (flush),
    .reg_write_i    (reg_write),
    .rd_i           (rd),
    .result_src_i   (result_src),
    .load_funct3_i  (load_funct3),
    .alu_result_i   (alu_result),
    .read_data_i    (read_data),
    .pc_plus4_i     (pc_plus4),
    .imm_i          (imm),
    .wb_valid_o     (wb_valid),
    .rf_we_o        (rf_we),
    .rf_waddr_o     (rf_waddr),
    .rf_wdata_o     (rf_wdata),
    .wb_misalign_o  (wb_misalign),
    .retire_count_o (retire_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {misaligned, data} from the load/result rules, using plain arithmetic.
  function automatic logic [32:0] model_result(input logic [1:0] src, input logic [2:0] f3,
                                              input logic [31:0] alu, input logic [31:0] rdat,
                                              input logic [31:0] pc4, input logic [31:0] im);
    int unsigned off;
    logic [31:0] v;
    off = alu % 4;
    case (src)
      2'd0: return {1'b0, alu};
      2'd2: return {1'b0, pc4};
      2'd3: return {1'b0, im};
      default: begin
        if (f3 == 3'b000 || f3 == 3'b100) begin
          v = (rdat >> (8 * off)) & 32'hFF;
          if (f3 == 3'b000 && v > 127) v = v + 32'hFFFF_FF00;
          return {1'b0, v};
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          if (off % 2 != 0) return {1'b1, 32'h0};
          v = (rdat >> (16 * (off / 2))) & 32'hFFFF;
          if (f3 == 3'b001 && v > 32767) v = v + 32'hFFFF_0000;
          return {1'b0, v};
        end else begin
          if (off != 0) return {1'b1, 32'h0};
          return {1'b0, rdat};
        end
      end
    endcase
  endfunction

  logic        m_valid_e, m_we_e, m_mis_e;
  logic [4:0]  m_waddr_e;
  logic [31:0] m_wdata_e;
  int          m_cnt_e;

  always @(posedge clk or negedge rst_n) begin
    logic [32:0] r;
    if (!rst_n) begin
      m_valid_e <= 1'b0;
      m_we_e    <= 1'b0;
      m_mis_e   <= 1'b0;
      m_waddr_e <= '0;
      m_wdata_e <= '0;
      m_cnt_e   <= 0;
    end else if (m_valid && !flush) begin
      r = model_result(result_src, load_funct3, alu_result, read_data, pc_plus4, imm);
      m_valid_e <= 1'b1;
      m_mis_e   <= r[32];
      m_wdata_e <= r[31:0];
      m_waddr_e <= rd;
      m_we_e    <= reg_write && (rd != 0) && !r[32];
      if (CntEn) m_cnt_e <= (m_cnt_e + 1) % 16;
    end else begin
      m_valid_e <= 1'b0;
      m_we_e    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model wb_valid", 32'(wb_valid), 32'(m_valid_e));
    chk("model rf_we", 32'(rf_we), 32'(m_we_e));
    chk("model rf_waddr", 32'(rf_waddr), 32'(m_waddr_e));
    chk("model rf_wdata", rf_wdata, m_wdata_e);
    chk("model wb_misalign", 32'(wb_misalign), 32'(m_mis_e));
    chk("model retire_count", 32'(retire_count), 32'(m_cnt_e));
  end

  task automatic drive(input logic v, input logic fl, input logic rw, input logic [4:0] d,
                       input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic [31:0] pc4, input logic [31:0] im);
    m_valid = v; flush = fl; reg_write = rw; rd = d; result_src = src; load_funct3 = f3;
    alu_result = alu; read_data = rdat; pc_plus4 = pc4; imm = im;
  endtask

  task automatic send(input logic v, input logic fl, input logic rw, input logic [4:0] d,
                      input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                      input logic [31:0] rdat, input logic [31:0] pc4, input logic [31:0] im);
    @(negedge clk);
    drive(v, fl, rw, d, src, f3, alu, rdat, pc4, im);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 5'd3, 2'd0, 3'b010, 32'h55, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset wb_valid", 32'(wb_valid), 32'd0);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset retire_count", 32'(retire_count), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    send(1'b1, 1'b0, 1'b1, 5'd5, 2'd0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    chk("alu rf_we", 32'(rf_we), 32'd1);
    chk("alu rf_waddr", 32'(rf_waddr), 32'd5);
    chk("alu rf_wdata", rf_wdata, 32'h0000_1234);

    send(1'b1, 1'b0, 1'b1, 5'd6, 2'd1, 3'b000, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0);
    chk("lb rf_wdata", rf_wdata, 32'hFFFF_FF80);
    send(1'b1, 1'b0, 1'b1, 5'd6, 2'd1, 3'b100, 32'h3, 32'h80FF_7F01, 32'h0, 32'h0);
    chk("lbu rf_wdata", rf_wdata, 32'h0000_0080);

    send(1'b1, 1'b0, 1'b1, 5'd8, 2'd1, 3'b010, 32'h1000_0002, 32'hDEAD_BEEF, 32'h0, 32'h0);
    chk("mis lw wb_misalign", 32'(wb_misalign), 32'd1);
    chk("mis lw rf_we", 32'(rf_we), 32'd0);
    chk("mis lw rf_wdata", rf_wdata, 32'd0);
    chk("mis lw retire_count", 32'(retire_count), CntEn ? 32'd4 : 32'd0);

    send(1'b1, 1'b0, 1'b1, 5'd0, 2'd0, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0);
    chk("x0 wb_valid", 32'(wb_valid), 32'd1);
    chk("x0 rf_we", 32'(rf_we), 32'd0);

    send(1'b1, 1'b0, 1'b1, 5'd7, 2'd1, 3'b001, 32'h2, 32'h8001_1234, 32'h0, 32'h0);
    chk("lh hi rf_wdata", rf_wdata, 32'hFFFF_8001);
    send(1'b1, 1'b1, 1'b1, 5'd9, 2'd0, 3'b000, 32'h99, 32'h0, 32'h0, 32'h0);
    chk("flush wb_valid", 32'(wb_valid), 32'd0);
    chk("flush rf_we", 32'(rf_we), 32'd0);
    chk("flush hold rf_waddr", 32'(rf_waddr), 32'd7);
    chk("flush hold rf_wdata", rf_wdata, 32'hFFFF_8001);
    chk("flush retire_count", 32'(retire_count), CntEn ? 32'd6 : 32'd0);

    send(1'b1, 1'b0, 1'b1, 5'd7, 2'd1, 3'b101, 32'h2, 32'h8001_1234, 32'h0, 32'h0);
    chk("lhu hi rf_wdata", rf_wdata, 32'h0000_8001);
    send(1'b1, 1'b0, 1'b1, 5'd7, 2'd1, 3'b001, 32'h1, 32'h8001_1234, 32'h0, 32'h0);
    chk("lh odd wb_misalign", 32'(wb_misalign), 32'd1);
    send(1'b1, 1'b0, 1'b1, 5'd4, 2'd1, 3'b111, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0);
    chk("f3 111 as lw", rf_wdata, 32'hCAFE_F00D);
    chk("lw aligned misalign", 32'(wb_misalign), 32'd0);
    send(1'b1, 1'b0, 1'b1, 5'd4, 2'd2, 3'b010, 32'h2, 32'h0, 32'h0000_0104, 32'h0);
    chk("pc4 not misaligned", 32'(wb_misalign), 32'd0);
    chk("pc4 rf_wdata", rf_wdata, 32'h0000_0104);
    send(1'b1, 1'b0, 1'b1, 5'd4, 2'd3, 3'b010, 32'h1, 32'h0, 32'h0, 32'hFFFF_F800);
    chk("imm rf_wdata", rf_wdata, 32'hFFFF_F800);

    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), 1'($urandom),
           5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
    end

    // Asynchronous reset mid-cycle, with a bundle still presented.
    send(1'b1, 1'b0, 1'b1, 5'd12, 2'd0, 3'b000, 32'hABCD, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst wb_valid", 32'(wb_valid), 32'd0);
    chk("async rst rf_waddr", 32'(rf_waddr), 32'd0);
    chk("async rst rf_wdata", rf_wdata, 32'd0);
    chk("async rst retire_count", 32'(retire_count), 32'd0);
    @(posedge clk);
    #1;
    chk("in rst discard", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first capture valid", 32'(wb_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 1'b0, 1'b1, 5'd1, 2'd0, 3'b000, 32'(i), 32'h0, 32'h0, 32'h0);
    end
    chk("wrap retire_count", 32'(retire_count), CntEn ? 32'd1 : 32'd0);

    send(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width; only 32 is supported.
REQ-002 Parameter RF_AW, default 5, SHALL set the register-file address width.
REQ-003 Parameter CNT_W, default 32, SHALL set the retire-counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 m_valid  input  1  SHALL mark the memory-stage bundle as valid.
REQ-007 flush  input  1  SHALL synchronously discard the bundle presented this cycle.
REQ-008 reg_write  input  1  SHALL request a register-file write.
REQ-009 rd  input  RF_AW  SHALL give the destination register.
REQ-010 result_src  input  2  SHALL select the result: 0 ALU, 1 load data, 2 PC+4, 3 immediate.
REQ-011 load_funct3  input  3  SHALL give the load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 alu_result, read_data, pc_plus4, imm  input  XLEN each  SHALL be the result sources.
REQ-013 wb_valid  output  1  SHALL mark the retired-instruction slot as valid.
REQ-014 rf_we, rf_waddr (RF_AW), rf_wdata (XLEN)  output  SHALL be the register-file write port.
REQ-015 wb_misalign  output  1  SHALL flag a misaligned load in the retired slot.
REQ-016 retire_count  output  CNT_W  SHALL give the number of retired instructions.

Function
REQ-017 Capture: at the clock edge with m_valid=1 and flush=0, the block SHALL register the bundle and set wb_valid=1 on the next cycle; otherwise wb_valid=0 on the next cycle (latency is exactly one cycle; the stage never stalls).
REQ-018 flush=1 SHALL take priority over m_valid: nothing is captured, wb_valid=0, rf_we=0 on the next cycle.
REQ-019 Load alignment SHALL use byte offset alu_result[1:0]: LB/LBU select byte[offset]; LH/LHU select halfword[offset[1]]; LW passes the word unchanged.
REQ-020 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to XLEN.
REQ-021 Unlisted load_funct3 codes (011, 110, 111) SHALL be treated as LW.
REQ-022 Misalignment SHALL be defined as LH/LHU with offset[0]=1, or LW with offset≠0, and is evaluated only when result_src=1.
REQ-023 On a misaligned capture, wb_misalign SHALL be 1, rf_we SHALL be 0 and rf_wdata SHALL be 0.
REQ-024 rf_we SHALL be wb_valid AND reg_write AND (rd≠0) AND NOT wb_misalign, so writes to x0 are suppressed.
REQ-025 rf_wdata SHALL hold the selected and aligned result; rf_waddr SHALL hold the captured rd.
REQ-026 Outputs SHALL hold their last values while wb_valid=0, except rf_we, which SHALL be 0.
REQ-027 retire_count SHALL increment by 1 on each capture, including x0 and misaligned captures, and SHALL wrap modulo 2^CNT_W.

Reset
REQ-028 rst=0 SHALL immediately clear wb_valid, rf_we, rf_waddr, rf_wdata, wb_misalign and retire_count to 0, independent of clk.
REQ-029 A bundle presented while rst=0 SHALL be discarded.
REQ-030 The first capture SHALL occur at the first rising edge after rst returns to 1.

Configuration
REQ-031 Macro WB_RETIRE_CNT_EN defined: the retire counter SHALL be built as specified in REQ-027.
REQ-032 Macro WB_RETIRE_CNT_EN undefined: retire_count SHALL be tied to 0 and no counter flops SHALL exist; all other behaviour is unchanged.

Verification
REQ-033 ALU result write: result_src=0, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x0000_1234.
REQ-034 LB sign extension: read_data=0x80FF_7F01, alu_result[1:0]=3, funct3=000 -> rf_wdata=0xFFFF_FF80; the same stimulus with LBU -> rf_wdata=0x0000_0080.
REQ-035 Misaligned LW: alu_result=0x...2, funct3=010 -> wb_misalign=1, rf_we=0, rf_wdata=0, retire_count+1.
REQ-036 x0 and flush: rd=0 -> rf_we=0 with wb_valid=1; flush=1 with m_valid=1 -> wb_valid=0 and retire_count unchanged.
REQ-037 Reset and wrap: assert rst mid-stream -> all outputs 0 asynchronously; with CNT_W=4, 17 captures -> retire_count=1 (macro defined) or 0 (macro undefined).
